// File: rtl/anita3_trig_pkg.sv
// Shared trigger constants: phi-sector geometry, mask bit layout and default widths.
package anita3_trig_pkg;

  localparam int unsigned NUM_PHI    = 16;
  localparam int unsigned NUM_POL    = 2;
  localparam int unsigned NUM_CH     = NUM_POL * NUM_PHI;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned HOLD_W_DEF = 4;
  localparam int unsigned WINDOW_DEF = 250000;
  localparam int unsigned SEL_W      = $clog2(NUM_CH);

  // Mask bit layout is {H[NUM_PHI-1:0], V[NUM_PHI-1:0]}
  localparam int unsigned V_OFS = 0;
  localparam int unsigned H_OFS = NUM_PHI;

  typedef logic [NUM_CH-1:0] phi_mask_t;

endpackage

// File: rtl/anita3_phi_auto_mask_ctrl_if.sv
// Software mask write port: strobe plus data, answered by a one-cycle acknowledge.
interface anita3_phi_auto_mask_ctrl_if;
  import anita3_trig_pkg::*;

  logic      mask_wr;
  phi_mask_t mask_dat;
  logic      mask_ack;

  modport master (output mask_wr, output mask_dat, input mask_ack);
  modport slave  (input mask_wr, input mask_dat, output mask_ack);

endinterface

// File: rtl/anita3_phi_rate_chan.sv
// One phi/pol channel: rising-edge counter over the gate window, latched rate,
// and the auto-mask bit with its hold-off counter.
module anita3_phi_rate_chan
  import anita3_trig_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned HOLD_W = HOLD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              phi_i,
  input  logic              win_end_i,
  input  logic              auto_en_i,
  input  logic [CNT_W-1:0]  thresh_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic [CNT_W-1:0]  latched_o,
  output logic              auto_o
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic              prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  latched_q, latched_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              auto_q, auto_d;
  logic              edge_c;
  logic [SUM_W-1:0]  sum_c;
  logic [CNT_W-1:0]  fin_c;

  always_comb begin
    edge_c    = phi_i & ~prev_q;
    sum_c     = {1'b0, cnt_q} + SUM_W'(edge_c);
    fin_c     = sum_c[CNT_W] ? '1 : sum_c[CNT_W-1:0];
    cnt_d     = win_end_i ? '0 : fin_c;
    latched_d = win_end_i ? fin_c : latched_q;
    hold_d    = hold_q;
    auto_d    = auto_q;
    // Disable wins over any window-end decision
    if (!auto_en_i) begin
      hold_d = '0;
      auto_d = 1'b0;
    end else if (win_end_i) begin
      if (fin_c > thresh_i) begin
        auto_d = 1'b1;
        hold_d = hold_i;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else begin
        auto_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      latched_q <= '0;
      hold_q    <= '0;
      auto_q    <= 1'b0;
    end else begin
      prev_q    <= phi_i;
      cnt_q     <= cnt_d;
      latched_q <= latched_d;
      hold_q    <= hold_d;
      auto_q    <= auto_d;
    end
  end

  assign latched_o = latched_q;
  assign auto_o    = auto_q;

endmodule

// File: rtl/anita3_phi_auto_mask_ctrl.sv
// Phi-sector mask controller: per-channel rate gating with auto-masking, merged
// with the software mask to drive the L1->phi map mask input.
module anita3_phi_auto_mask_ctrl
  import anita3_trig_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned HOLD_W = HOLD_W_DEF
) (
  input  logic                       clk250_i,
  input  logic                       rst_i,
  input  logic [NUM_PHI-1:0]         V_pol_phi_i,
  input  logic [NUM_PHI-1:0]         H_pol_phi_i,
  anita3_phi_auto_mask_ctrl_if.slave sw_bus,
  input  logic                       auto_en_i,
  input  logic [CNT_W-1:0]           thresh_i,
  input  logic [HOLD_W-1:0]          hold_i,
  input  logic [SEL_W-1:0]           rate_sel_i,
  output logic [CNT_W-1:0]           rate_o,
  output logic                       window_o,
  output phi_mask_t                  auto_mask_o,
  output phi_mask_t                  mask_o
);

  localparam int unsigned WIN_W = $clog2(WINDOW);

  logic [WIN_W-1:0] win_q, win_d;
  logic             window_q, window_d;
  phi_mask_t        sw_q, sw_d;
  phi_mask_t        mask_q, mask_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  phi_mask_t        phi_c;
  phi_mask_t        auto_c;
  logic [CNT_W-1:0] latched_c [NUM_CH];

  always_comb begin
    phi_c                    = '0;
    phi_c[V_OFS +: NUM_PHI]  = V_pol_phi_i;
    phi_c[H_OFS +: NUM_PHI]  = H_pol_phi_i;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    anita3_phi_rate_chan #(
      .CNT_W  (CNT_W),
      .HOLD_W (HOLD_W)
    ) u_chan (
      .clk_i     (clk250_i),
      .rst_i     (rst_i),
      .phi_i     (phi_c[c]),
      .win_end_i (window_q),
      .auto_en_i (auto_en_i),
      .thresh_i  (thresh_i),
      .hold_i    (hold_i),
      .latched_o (latched_c[c]),
      .auto_o    (auto_c[c])
    );
  end

  // window_q is pre-decoded so it is high exactly while win_q == WINDOW-1
  always_comb begin
    win_d    = (win_q == WIN_W'(WINDOW - 1)) ? '0 : win_q + WIN_W'(1);
    window_d = (win_d == WIN_W'(WINDOW - 1));
    sw_d     = sw_bus.mask_wr ? sw_bus.mask_dat : sw_q;
    ack_d    = sw_bus.mask_wr;
    mask_d   = sw_q | auto_c;
    rate_d   = latched_c[rate_sel_i];
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      win_q    <= '0;
      window_q <= 1'b0;
      sw_q     <= '0;
      mask_q   <= '0;
      ack_q    <= 1'b0;
      rate_q   <= '0;
    end else begin
      win_q    <= win_d;
      window_q <= window_d;
      sw_q     <= sw_d;
      mask_q   <= mask_d;
      ack_q    <= ack_d;
      rate_q   <= rate_d;
    end
  end

  assign sw_bus.mask_ack = ack_q;
  assign rate_o          = rate_q;
  assign window_o        = window_q;
  assign auto_mask_o     = auto_c;
  assign mask_o          = mask_q;

endmodule

// File: tb/tb_anita3_phi_auto_mask_ctrl.sv
// Directed bench for the phi auto-mask controller; a second instance with a long
// window exercises counter saturation.
module tb_anita3_phi_auto_mask_ctrl;
  import anita3_trig_pkg::*;

  localparam int unsigned WIN  = 100;
  localparam int unsigned WIN2 = 640;
  localparam int unsigned CW   = 8;
  localparam int unsigned HW   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_PHI-1:0] v_phi, h_phi, v2_phi, h2_phi;
  logic               auto_en, auto_en2;
  logic [CW-1:0]      thresh, thresh2;
  logic [HW-1:0]      hold, hold2;
  logic [SEL_W-1:0]   sel, sel2;
  logic [CW-1:0]      rate, rate2;
  logic               win, win2;
  phi_mask_t          auto_m, mask, auto_m2, mask2;

  int n_chk = 0;
  int n_err = 0;

  anita3_phi_auto_mask_ctrl_if sw_if  ();
  anita3_phi_auto_mask_ctrl_if sw_if2 ();

  always #2 clk = ~clk;

  anita3_phi_auto_mask_ctrl #(.WINDOW(WIN), .CNT_W(CW), .HOLD_W(HW)) u_dut (
    .clk250_i    (clk),
    .rst_i       (rst),
    .V_pol_phi_i (v_phi),
    .H_pol_phi_i (h_phi),
    .sw_bus      (sw_if),
    .auto_en_i   (auto_en),
    .thresh_i    (thresh),
    .hold_i      (hold),
    .rate_sel_i  (sel),
    .rate_o      (rate),
    .window_o    (win),
    .auto_mask_o (auto_m),
    .mask_o      (mask)
  );

  anita3_phi_auto_mask_ctrl #(.WINDOW(WIN2), .CNT_W(CW), .HOLD_W(HW)) u_dut_sat (
    .clk250_i    (clk),
    .rst_i       (rst),
    .V_pol_phi_i (v2_phi),
    .H_pol_phi_i (h2_phi),
    .sw_bus      (sw_if2),
    .auto_en_i   (auto_en2),
    .thresh_i    (thresh2),
    .hold_i      (hold2),
    .rate_sel_i  (sel2),
    .rate_o      (rate2),
    .window_o    (win2),
    .auto_mask_o (auto_m2),
    .mask_o      (mask2)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge where window_o is high (the last cycle of a window)
  task automatic wait_win(input bit second, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((second ? win2 : win) !== 1'b1) && n < 2000);
    chk(tag, 64'(second ? win2 : win), 64'd1);
  endtask

  task automatic pulses(input bit hpol, input int ch, input int n);
    repeat (n) begin
      if (hpol) h_phi[ch] = 1'b1; else v_phi[ch] = 1'b1;
      tick(1);
      if (hpol) h_phi[ch] = 1'b0; else v_phi[ch] = 1'b0;
      tick(1);
    end
  endtask

  task automatic sw_write(input logic [31:0] d);
    sw_if.mask_wr  = 1'b1;
    sw_if.mask_dat = d;
    tick(1);
    sw_if.mask_wr  = 1'b0;
  endtask

  initial begin
    int first;
    rst = 1'b1;
    v_phi = '0; h_phi = '0; v2_phi = '0; h2_phi = '0;
    auto_en = 1'b0; thresh = '0; hold = '0; sel = '0;
    auto_en2 = 1'b0; thresh2 = '0; hold2 = '0; sel2 = '0;
    sw_if.mask_wr = 1'b0;  sw_if.mask_dat = '0;
    sw_if2.mask_wr = 1'b0; sw_if2.mask_dat = '0;
    tick(3);
    rst = 1'b0;

    // Reset mid-window with activity
    sw_write(32'hFFFF_FFFF);
    auto_en = 1'b1;
    repeat (20) begin
      v_phi = ~v_phi;
      h_phi = ~h_phi;
      tick(1);
    end
    chk("pre_rst_mask", mask, 64'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    chk("rst_mask", mask, 64'd0);
    chk("rst_auto", auto_m, 64'd0);
    chk("rst_rate_win_ack", {rate, win, sw_if.mask_ack}, 64'd0);
    chk("rst_dut2_masks", {mask2, auto_m2}, 64'd0);
    chk("rst_dut2_rate_win_ack", {rate2, win2, sw_if2.mask_ack}, 64'd0);
    v_phi = '0; h_phi = '0; auto_en = 1'b0;
    tick(2);
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 150; k++) begin
      tick(1);
      if (win === 1'b1) begin
        first = k;
        break;
      end
    end
    chk("first_window_cycle", 64'(first), 64'd99);

    // Counting: 5 pulses plus one 20-cycle level on V3
    sel = 5'd3;
    tick(1);
    pulses(1'b0, 3, 5);
    v_phi[3] = 1'b1;
    tick(20);
    v_phi[3] = 1'b0;
    wait_win(1'b0, "w_cnt");
    chk("rate_before_end", rate, 64'd0);
    tick(2);
    chk("rate_v3", rate, 64'd6);

    // Boundary: V5 edge on the window_o cycle, V6 edge on the next cycle
    wait_win(1'b0, "w_bnd");
    v_phi[5] = 1'b1;
    tick(1);
    v_phi[5] = 1'b0;
    v_phi[6] = 1'b1;
    tick(1);
    v_phi[6] = 1'b0;
    sel = 5'd5;
    tick(1);
    chk("bnd_edge_at_window_o", rate, 64'd1);
    sel = 5'd6;
    tick(1);
    chk("bnd_next_cycle_old", rate, 64'd0);
    wait_win(1'b0, "w_bnd2");
    tick(2);
    chk("bnd_next_cycle_new", rate, 64'd1);
    sel = 5'd5;
    tick(1);
    chk("bnd_v5_new", rate, 64'd0);

    // Trip on H7 (5 > 4), V2 at exactly 4 must not trip
    auto_en = 1'b1; thresh = 8'd4; hold = 4'd2;
    wait_win(1'b0, "w_trip");
    tick(1);
    for (int i = 0; i < 5; i++) begin
      h_phi[7] = 1'b1;
      if (i < 4) v_phi[2] = 1'b1;
      tick(1);
      h_phi[7] = 1'b0;
      v_phi[2] = 1'b0;
      tick(1);
    end
    wait_win(1'b0, "w_trip_e0");
    chk("trip_pre_end", auto_m, 64'd0);
    tick(1);
    chk("trip_auto_set", auto_m, 64'h0080_0000);
    chk("trip_mask_lag", mask, 64'd0);
    tick(1);
    chk("trip_mask_set", mask, 64'h0080_0000);
    for (int w = 1; w <= 3; w++) begin
      wait_win(1'b0, "w_hold");
      tick(1);
      chk($sformatf("hold_w%0d", w), auto_m, (w < 3) ? 64'h0080_0000 : 64'd0);
    end
    tick(1);
    chk("hold_mask_clr", mask, 64'd0);

    // Re-trip in window 2 extends the mask to the end of window 5
    pulses(1'b1, 7, 5);
    wait_win(1'b0, "w_re0");
    tick(1);
    chk("retrip_w1", auto_m, 64'h0080_0000);
    wait_win(1'b0, "w_re1");
    tick(1);
    pulses(1'b1, 7, 5);
    wait_win(1'b0, "w_re2");
    tick(1);
    chk("retrip_w3", auto_m, 64'h0080_0000);
    for (int w = 3; w <= 5; w++) begin
      wait_win(1'b0, "w_re");
      tick(1);
      chk($sformatf("retrip_end_w%0d", w), auto_m, (w < 5) ? 64'h0080_0000 : 64'd0);
    end

    // Software write timing and back-to-back writes
    sw_if.mask_wr  = 1'b1;
    sw_if.mask_dat = 32'h0000_8001;
    tick(1);
    chk("wr_ack", 64'(sw_if.mask_ack), 64'd1);
    chk("wr_mask_old", mask, 64'd0);
    sw_if.mask_wr = 1'b0;
    tick(1);
    chk("wr_mask_new", mask, 64'h0000_8001);
    chk("wr_ack_pulse", 64'(sw_if.mask_ack), 64'd0);
    sw_if.mask_wr  = 1'b1;
    sw_if.mask_dat = 32'h0000_1111;
    tick(1);
    sw_if.mask_dat = 32'h0000_2222;
    tick(1);
    sw_if.mask_wr = 1'b0;
    tick(1);
    chk("wr_b2b_last", mask, 64'h0000_2222);

    // Write coinciding with window_o plus a pending trip
    wait_win(1'b0, "w_wrw");
    tick(1);
    pulses(1'b1, 7, 5);
    wait_win(1'b0, "w_wrw_end");
    sw_if.mask_wr  = 1'b1;
    sw_if.mask_dat = 32'h0000_0004;
    tick(1);
    sw_if.mask_wr = 1'b0;
    chk("wrw_ack", 64'(sw_if.mask_ack), 64'd1);
    chk("wrw_auto", auto_m, 64'h0080_0000);
    tick(1);
    chk("wrw_mask", mask, 64'h0080_0004);
    sw_write(32'h0000_8001);
    tick(1);
    chk("wr_with_auto", mask, 64'h0080_8001);

    // Disable clears auto bits next cycle, mask follows one cycle later
    auto_en = 1'b0;
    tick(1);
    chk("dis_auto", auto_m, 64'd0);
    chk("dis_mask_lag", mask, 64'h0080_8001);
    tick(1);
    chk("dis_mask", mask, 64'h0000_8001);

    // Saturation: 300 edges in one long window
    wait_win(1'b1, "w2_sync");
    tick(1);
    repeat (300) begin
      v2_phi[0] = 1'b1;
      tick(1);
      v2_phi[0] = 1'b0;
      tick(1);
    end
    wait_win(1'b1, "w2_end");
    tick(2);
    chk("sat_rate", rate2, 64'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
